// File: rtl/adder_la_sequencer.sv
// LA-side stimulus/response sequencer for the instrumented adder wrapper.
// Loads operands, runs the adder, times completion, captures and checks the sum.
module adder_la_sequencer #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_carry,
  output logic [CNT_W-1:0] rsp_cycles,
  output logic             rsp_error,
  output logic             rsp_timeout,
  output logic [WIDTH-1:0] la_a,
  output logic [WIDTH-1:0] la_b,
  output logic             la_load,
  output logic             la_run,
  output logic             la_capture,
  input  logic [WIDTH-1:0] la_sum,
  input  logic             la_carry,
  input  logic             la_done,
  output logic [CNT_W-1:0] stat_runs,
  output logic [CNT_W-1:0] stat_errors
);

  localparam logic [CNT_W-1:0] TO_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_CAP, S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] la_a_q, la_b_q;
  logic [WIDTH:0]   gold_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cyc_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q, err_q, to_q;
  logic [CNT_W-1:0] runs_q, errs_q;

  logic [CNT_W-1:0] cnt_inc;
  logic             run_end, accept, hshake;

  assign cnt_inc = cnt_q + ONE;
  assign run_end = (state_q == S_RUN) && (la_done || cnt_inc == TO_C);
  assign accept  = (state_q == S_IDLE) && cmd_valid;
  assign hshake  = (state_q == S_RESP) && rsp_ready;

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (cmd_valid) state_d = S_LOAD;
      S_LOAD:  state_d = S_RUN;
      S_RUN:   if (run_end) state_d = S_CAP;
      S_CAP:   state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control outputs decoded from the registered state
  always_comb begin
    cmd_ready  = (state_q == S_IDLE);
    la_load    = (state_q == S_LOAD);
    la_run     = (state_q == S_RUN);
    la_capture = (state_q == S_CAP);
    rsp_valid  = (state_q == S_RESP);
  end

  // Operand, timing, capture and statistics datapath
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      la_a_q  <= '0;
      la_b_q  <= '0;
      gold_q  <= '0;
      cnt_q   <= '0;
      cyc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      runs_q  <= '0;
      errs_q  <= '0;
    end else begin
      if (accept) begin
        la_a_q <= cmd_a;
        la_b_q <= cmd_b;
        gold_q <= {1'b0, cmd_a} + {1'b0, cmd_b};
      end
      if (state_q == S_LOAD) begin
        cnt_q <= '0;
        to_q  <= 1'b0;
      end
      if (state_q == S_RUN) begin
        cnt_q <= cnt_inc;
        if (la_done) begin
          cyc_q <= cnt_inc;
        end else if (cnt_inc == TO_C) begin
          cyc_q <= TO_C;
          to_q  <= 1'b1;
        end
      end
      if (state_q == S_CAP) begin
        sum_q   <= la_sum;
        carry_q <= la_carry;
        err_q   <= ({la_carry, la_sum} != gold_q);
      end
      if (hshake) begin
        if (runs_q != '1) runs_q <= runs_q + ONE;
        if ((err_q || to_q) && errs_q != '1)
          errs_q <= errs_q + ONE;
      end
    end
  end

  assign la_a        = la_a_q;
  assign la_b        = la_b_q;
  assign rsp_sum     = sum_q;
  assign rsp_carry   = carry_q;
  assign rsp_cycles  = cyc_q;
  assign rsp_error   = err_q;
  assign rsp_timeout = to_q;
  assign stat_runs   = runs_q;
  assign stat_errors = errs_q;

endmodule

// File: tb/tb_adder_la_sequencer.sv
// Self-checking bench for adder_la_sequencer.
// Randomized operand/timing stimulus against a transaction-level model.
module tb_adder_la_sequencer;

  localparam int W   = 32;
  localparam int TO  = 1023;
  localparam int CW  = 10;
  localparam int MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [W-1:0]  cmd_a = '0;
  logic [W-1:0]  cmd_b = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_sum;
  logic          rsp_carry;
  logic [CW-1:0] rsp_cycles;
  logic          rsp_error;
  logic          rsp_timeout;
  logic [W-1:0]  la_a, la_b;
  logic          la_load, la_run, la_capture;
  logic [W-1:0]  m_sum = '0;
  logic          m_carry = 1'b0;
  logic          la_done;
  logic [CW-1:0] stat_runs, stat_errors;

  int errors = 0;
  int checks = 0;
  int exp_runs = 0;
  int exp_errs = 0;
  int done_at = 0;
  int run_seen = 0;

  always #5 clk = ~clk;

  adder_la_sequencer #(.WIDTH(W), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_carry(rsp_carry),
    .rsp_cycles(rsp_cycles), .rsp_error(rsp_error),
    .rsp_timeout(rsp_timeout),
    .la_a(la_a), .la_b(la_b),
    .la_load(la_load), .la_run(la_run), .la_capture(la_capture),
    .la_sum(m_sum), .la_carry(m_carry), .la_done(la_done),
    .stat_runs(stat_runs), .stat_errors(stat_errors)
  );

  // Adder model: raises done in its done_at-th RUN cycle (0 = never)
  assign la_done = la_run && (done_at != 0) && (run_seen + 1 == done_at);

  always @(posedge clk) begin
    if (la_load)     run_seen <= 0;
    else if (la_run) run_seen <= run_seen + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bump_stats(input bit bad);
    if (exp_runs < MAX) exp_runs++;
    if (bad && exp_errs < MAX) exp_errs++;
  endtask

  // One complete transaction; corrupt flips the adder model's carry
  task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int dat, input bit corrupt);
    logic [W:0] gold, got;
    int lat, cap, exp_cyc;
    bit exp_to, exp_err, excl_bad;
    gold = {1'b0, a} + {1'b0, b};
    got = corrupt ? (gold ^ {1'b1, {W{1'b0}}}) : gold;
    {m_carry, m_sum} = got;
    done_at = dat;
    exp_to = (dat == 0) || (dat > TO);
    exp_cyc = exp_to ? TO : dat;
    exp_err = (got != gold);
    lat = 0;
    while (!cmd_ready && lat < 20) begin step(); lat++; end
    cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    checks++;
    if (la_load !== 1'b1 || la_a !== a || la_b !== b) begin
      errors++;
      $display("FAIL load: la_load=%b la_a=%h la_b=%h want 1 %h %h",
               la_load, la_a, la_b, a, b);
    end
    lat = 1; cap = 0; excl_bad = 0;
    while (!rsp_valid && lat < TO + 20) begin
      if (int'(la_load) + int'(la_run) + int'(la_capture) > 1) excl_bad = 1;
      cap += int'(la_capture);
      step();
      lat++;
    end
    checks++;
    if (lat != exp_cyc + 3) begin
      errors++;
      $display("FAIL latency: got %0d want %0d", lat, exp_cyc + 3);
    end
    checks++;
    if (cap != 1 || excl_bad) begin
      errors++;
      $display("FAIL strobes: capture pulses %0d excl_bad %0d want 1 0",
               cap, excl_bad);
    end
    checks++;
    if ({rsp_carry, rsp_sum} !== got) begin
      errors++;
      $display("FAIL rsp_sum: got %h want %h", {rsp_carry, rsp_sum}, got);
    end
    checks++;
    if (int'(rsp_cycles) != exp_cyc || rsp_timeout !== exp_to) begin
      errors++;
      $display("FAIL rsp_cycles: got %0d/%b want %0d/%b",
               rsp_cycles, rsp_timeout, exp_cyc, exp_to);
    end
    if (!exp_to) begin
      checks++;
      if (rsp_error !== exp_err) begin
        errors++;
        $display("FAIL rsp_error: got %b want %b", rsp_error, exp_err);
      end
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    bump_stats(exp_err || exp_to);
    checks++;
    if (int'(stat_runs) != exp_runs || int'(stat_errors) != exp_errs
        || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL stats: runs %0d errs %0d rdy %b want %0d %0d 1",
               stat_runs, stat_errors, cmd_ready, exp_runs, exp_errs);
    end
    done_at = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || la_load !== 1'b0
        || la_run !== 1'b0 || la_capture !== 1'b0 || la_a !== '0
        || stat_runs !== '0 || stat_errors !== '0) begin
      errors++;
      $display("FAIL reset: rdy %b vld %b ld %b run %b cap %b runs %0d",
               cmd_ready, rsp_valid, la_load, la_run, la_capture, stat_runs);
    end
  endtask

  task automatic test_basic();
    do_txn(32'h3, 32'h4, 1, 0);
  endtask

  task automatic test_carry();
    do_txn(32'hFFFF_FFFF, 32'h1, 5, 0);
    do_txn(32'hFFFF_FFFF, 32'h1, 5, 1);
  endtask

  task automatic test_timeout();
    do_txn(32'h1234_5678, 32'h1111_1111, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      do_txn($urandom, $urandom, int'($urandom_range(1, 12)),
             ($urandom_range(0, 3) == 0));
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2;
    logic [W:0] g1, g2;
    int lat;
    bit bad;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    g1 = {1'b0, a1} + {1'b0, b1};
    g2 = {1'b0, a2} + {1'b0, b2};
    {m_carry, m_sum} = g1;
    done_at = 2;
    cmd_a = a1; cmd_b = b1; cmd_valid = 1'b1;
    step();
    cmd_a = a2; cmd_b = b2;
    lat = 0;
    while (!rsp_valid && lat < 50) begin step(); lat++; end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || {rsp_carry, rsp_sum} !== g1
          || cmd_ready !== 1'b0 || la_a !== a1 || la_load !== 1'b0)
        bad = 1;
      step();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL hold: rsp %h vld %b rdy %b want %h 1 0",
               {rsp_carry, rsp_sum}, rsp_valid, cmd_ready, g1);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    bump_stats(0);
    checks++;
    if (cmd_ready !== 1'b1 || la_load !== 1'b0 || la_a !== a1) begin
      errors++;
      $display("FAIL idle_gap: rdy %b ld %b la_a %h want 1 0 %h",
               cmd_ready, la_load, la_a, a1);
    end
    {m_carry, m_sum} = g2;
    done_at = 1;
    step();
    cmd_valid = 1'b0;
    checks++;
    if (la_load !== 1'b1 || la_a !== a2 || la_b !== b2) begin
      errors++;
      $display("FAIL accept2: ld %b la_a %h want 1 %h", la_load, la_a, a2);
    end
    lat = 0;
    while (!rsp_valid && lat < 50) begin step(); lat++; end
    checks++;
    if ({rsp_carry, rsp_sum} !== g2 || rsp_error !== 1'b0) begin
      errors++;
      $display("FAIL rsp2: got %h err %b want %h 0",
               {rsp_carry, rsp_sum}, rsp_error, g2);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    bump_stats(0);
    done_at = 0;
  endtask

  task automatic test_reset_mid_run();
    done_at = 0;
    cmd_a = $urandom; cmd_b = $urandom; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_runs = 0;
    exp_errs = 0;
    checks++;
    if (la_run !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1
        || stat_runs !== '0 || stat_errors !== '0 || la_a !== '0) begin
      errors++;
      $display("FAIL mid_reset: run %b vld %b rdy %b runs %0d errs %0d",
               la_run, rsp_valid, cmd_ready, stat_runs, stat_errors);
    end
    do_txn($urandom, $urandom, 3, 0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < MAX + 6; i++)
      do_txn($urandom, $urandom, 1, 0);
    checks++;
    if (int'(stat_runs) != MAX) begin
      errors++;
      $display("FAIL saturate: stat_runs %0d want %0d", stat_runs, MAX);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_la_sequencer.md
# adder_la_sequencer

On-chip stimulus/response sequencer that drives the logic-analyser side of an instrumented adder wrapper, the host end of the LA protocol the adder wrapper consumes. It accepts an operand pair over a valid/ready command port, then presents the operands on the LA output buses and pulses the load/run/capture controls. It then times the adder's completion, captures the sum and carry-out, checks them against an internally computed golden sum, and returns a response over a valid/ready response port. It sits between the Wishbone-side control logic and the wrapped adder's la1/la2/la3 buses.

## Interface
Parameters:
- WIDTH, 32, operand and sum width
- TIMEOUT, 1023, maximum RUN cycles before abort; must be ≥1 and ≤ 2^CNT_W−1
- CNT_W, 16, width of cycle and statistics counters

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge
- wb_rst_i  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_a  in  WIDTH  operand A
- cmd_b  in  WIDTH  operand B
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer ready
- rsp_sum  out  WIDTH  captured la_sum
- rsp_carry  out  1  captured la_carry
- rsp_cycles  out  CNT_W  RUN cycles until done (or TIMEOUT)
- rsp_error  out  1  captured {carry,sum} ≠ golden cmd_a+cmd_b
- rsp_timeout  out  1  la_done never seen within TIMEOUT
- la_a  out  WIDTH  operand A to adder
- la_b  out  WIDTH  operand B to adder
- la_load  out  1  operand load strobe
- la_run  out  1  adder run enable
- la_capture  out  1  result capture strobe
- la_sum  in  WIDTH  adder sum
- la_carry  in  1  adder carry-out
- la_done  in  1  adder completion flag
- stat_runs  out  CNT_W  completed transactions, saturating
- stat_errors  out  CNT_W  transactions with rsp_error or rsp_timeout, saturating

## Operation
- FSM states are IDLE, LOAD, RUN, CAPTURE and RESP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, register cmd_a/cmd_b into la_a/la_b and register the golden sum (WIDTH+1 bits, unsigned) → LOAD.
- LOAD: exactly one cycle with la_load=1; RUN counter cleared → RUN.
- RUN: la_run=1; the counter increments each RUN cycle.
  - If la_done=1 in a RUN cycle, rsp_cycles = count including that cycle (done in first RUN cycle → 1) → CAPTURE.
  - If the counter reaches TIMEOUT with la_done=0, rsp_timeout=1, rsp_cycles=TIMEOUT → CAPTURE.
- CAPTURE: one cycle with la_capture=1 and la_run=0.
  - Register la_sum→rsp_sum, la_carry→rsp_carry.
  - rsp_error = ({la_carry,la_sum} ≠ golden).
  - This state is entered on timeout too.
- RESP: rsp_valid=1. All rsp_* outputs are held stable until rsp_valid&&rsp_ready, then → IDLE.
  - stat_runs increments on that handshake.
  - stat_errors increments on the same handshake if rsp_error|rsp_timeout.
  - Both counters saturate at all-ones.
- la_a/la_b hold their last values after a transaction until the next accepted command.
- cmd_ready=0 in every state except IDLE. A command presented while busy is not accepted and is not lost: the source keeps it valid.
- la_load, la_run and la_capture are mutually exclusive and never asserted in IDLE or RESP.
- la_done is ignored outside RUN.
- Reset, including mid-transaction:
  - FSM → IDLE.
  - All outputs 0 except cmd_ready=1.
  - The la_* strobes deassert the cycle after reset is sampled.
  - Statistics counters clear.
  - Any in-flight response is discarded.

## Timing
- Command accepted at edge N gives:
  - la_load high in cycle N+1.
  - la_run high from N+2.
- la_done sampled high at edge M (in RUN) gives:
  - la_capture high in cycle M+1.
  - rsp_valid high from M+2.
- Minimum latency is 4 cycles from command-accept edge to rsp_valid (done in first RUN cycle).
- Maximum latency is TIMEOUT+3 cycles.
- Minimum back-to-back period is 5 cycles per transaction (accept, LOAD, RUN, CAPTURE, RESP with rsp_ready=1). The next command is accepted in the IDLE cycle after the handshake.
- All outputs are registered. No combinational path from any input to any output except cmd_ready/rsp_valid state decode.

## Test plan
- Reset, then cmd a=0x0000_0003, b=0x0000_0004, adder model asserts la_done in 1st RUN cycle, sum 7 → rsp_sum=7, carry=0, cycles=1, error=0, rsp_valid 4 cycles after accept, stat_runs=1.
- a=0xFFFF_FFFF, b=1, done after 5 cycles, model returns sum 0, carry 1 → rsp_error=0, cycles=5. Repeat with model returning carry 0 → rsp_error=1, stat_errors=1.
- la_done held 0 → rsp_timeout=1, rsp_cycles=1023, la_capture still pulses once, stat_errors increments.
- rsp_ready held 0 for 10 cycles with a new cmd_valid pending → rsp_* stable, cmd_ready=0, new command accepted only in the IDLE cycle after the handshake.
- Assert wb_rst_i during RUN → next cycle la_run=0, rsp_valid=0, cmd_ready=1, stats 0. A fresh command then completes normally.
- 70000 passing transactions → stat_runs saturates at 0xFFFF.
